uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   UART receive path, the far-end partner of the TX-with-FIFO path: 8N1 deserialiser + RX byte FIFO.
//   Takes the asynchronous serial line, validates start/stop bits, stores good bytes in a sync FIFO.
//   Host drains bytes via a rd_en/valid interface. Framing and overrun errors are flagged.
// PARAMETERS
//   baud_cycles  5   clk cycles per bit (25 MHz / 5 Mbaud); must be >= 4
//   FIFO_DEPTH   16  RX FIFO entries; power of 2, >= 2
// PORTS
//   clk          in   1  single clock, all logic posedge
//   rst_n        in   1  asynchronous active-low reset
//   i_rxp        in   1  serial line, asynchronous, idle high
//   rd_en        in   1  host pops one byte; ignored when o_empty=1
//   o_rd_data    out  8  popped byte, valid when o_rd_valid=1
//   o_rd_valid   out  1  1-cycle pulse, cycle after an accepted rd_en
//   o_empty      out  1  FIFO holds no bytes
//   o_full       out  1  FIFO holds FIFO_DEPTH bytes
//   o_frame_err  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//   o_overrun    out  1  sticky: good byte arrived while FIFO full, byte discarded
//   i_clr_err    in   1  clears o_overrun (set wins if both same cycle)
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, counters 0, sync flops 1, FIFO pointers 0;
//     o_rd_data=0, o_rd_valid=0, o_empty=1, o_full=0, o_frame_err=0, o_overrun=0.
//   Input: i_rxp -> 2-flop synchroniser -> rx_s; rx_d = rx_s delayed 1 cycle; fall = rx_d & ~rx_s.
//   FSM (one-hot ST_IDLE/ST_START/ST_DATA/ST_STOP), baud_cnt clears on every state change:
//     IDLE : fall -> START, baud_cnt=0.
//     START: at baud_cnt==baud_cycles/2-1 sample rx_s; 0 -> DATA, 1 -> IDLE (glitch, no flag).
//     DATA : at baud_cnt==baud_cycles-1 sample rx_s into shift reg, LSB first; bits_cnt 0..7;
//            after bit 7 -> STOP.
//     STOP : at baud_cnt==baud_cycles-1 sample rx_s; 1 -> byte good; 0 -> o_frame_err pulse.
//            Either way -> IDLE same edge (mid-stop), so back-to-back frames are caught.
//   Good byte: FIFO write strobe next cycle; if o_full at that cycle -> drop, set o_overrun.
//   Stop low: line stays low, no new fall until it returns high; no false restart.
//   FIFO: extra-MSB pointers; full = MSBs differ & low bits equal; empty = pointers equal.
//     Write and read in same cycle while full: read wins its slot, write still dropped (full
//     sampled pre-edge). Same cycle while empty: read ignored, write accepted.
//   Read: rd_en & ~o_empty -> o_rd_data <= mem[rd_ptr], o_rd_valid=1 next cycle, rd_ptr++.
//     o_rd_data holds last value otherwise. o_empty/o_full update the cycle after the pointer edge.
//   Latency: stop-bit sample edge -> o_empty falls 2 cycles later (write, then flag).
//   Counters: baud_cnt width $clog2(baud_cycles+1); bits_cnt 3 bits, wraps 7->0 on STOP entry.
//   Reset mid-frame: everything returns to reset values immediately; partial byte lost.
// STRUCTURE
//   uart_pkg: rx state typedef (one-hot, 4 bits), UART_DATA_BITS=8, default baud_cycles.
//   Sub-module uart_rx (sync, FSM, shift reg; out: rx_data[7:0], rx_valid, rx_frame_err).
//   Top uart_rx_fifo: uart_rx + sync_fifo (DATA_WIDTH=8, DATA_DEPTH=FIFO_DEPTH), overrun flag,
//     rd_valid register. sync_fifo is reused unchanged except reset made async.
// TESTING (baud_cycles=5, FIFO_DEPTH=16; bench drives i_rxp with ideal 8N1 frames)
//   1 Frame 0xA5 -> o_empty falls; rd_en 1 cycle -> next cycle o_rd_valid=1, o_rd_data=0xA5.
//   2 16 back-to-back frames 0x00..0x0F, no gap -> o_full=1; read all 16 in order, o_empty=1.
//   3 17th frame 0xFF while full -> o_overrun=1, FIFO contents unchanged; i_clr_err -> 0.
//   4 Frame 0x3C with stop bit driven low -> o_frame_err one pulse, o_empty stays 1; line high
//     then frame 0x3C good -> read returns 0x3C.
//   5 Low glitch of 2 cycles on idle line -> no frame, no error, FSM back in IDLE.
//   6 rst_n low during bit 4 of 0x81 -> outputs at reset values; next full frame 0x81 received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit time
// and the one-hot receive state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int BAUD_CYCLES_DEF = 5;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers, registered
// flags and a registered read data port.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  wr_fire,
  output logic                  rd_fire
);

  localparam int AW = $clog2(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  empty_now;
  logic                  full_now;

  assign empty_now = (wr_ptr == rd_ptr);
  assign full_now  =
    (wr_ptr[AW] != rd_ptr[AW]) &&
    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // The flags lag the pointers by a cycle, so the live
  // compare also gates each side to keep pointers sane.
  assign wr_fire = wr_en & ~full & ~full_now;
  assign rd_fire = rd_en & ~empty & ~empty_now;

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointers, registered flags and read data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      empty <= empty_now;
      full  <= full_now;
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 deserialiser: synchroniser, edge detect, bit-timing
// FSM and shift register with registered byte/error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int baud_cycles = BAUD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxp,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(baud_cycles + 1);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(baud_cycles / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(baud_cycles - 1);
  localparam logic [2:0] LAST_BIT =
    3'(UART_DATA_BITS - 1);

  logic                      s1;
  logic                      rx_s;
  logic                      rx_d;
  logic                      fall;
  rx_state_t                 state;
  logic [CW-1:0]             baud_cnt;
  logic [2:0]                bits_cnt;
  logic [UART_DATA_BITS-1:0] shreg;

  // Two-flop synchroniser plus one delay stage for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      s1   <= rxp;
      rx_s <= s1;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  // Frame FSM: mid-bit sampling, stop check, result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      baud_cnt     <= '0;
      bits_cnt     <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            state    <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            bits_cnt <= bits_cnt + 1'b1;
            if (bits_cnt == LAST_BIT)
              state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          bits_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive path: 8N1 deserialiser feeding an RX byte
// FIFO, with frame-error pulse and sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int baud_cycles = BAUD_CYCLES_DEF,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rxp,
  input  logic       rd_en,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clr_err
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_fire;
  logic       rd_fire;

  uart_rx #(
    .baud_cycles (baud_cycles)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxp          (i_rxp),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (o_frame_err)
  );

  sync_fifo #(
    .DATA_WIDTH (UART_DATA_BITS),
    .DATA_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rx_valid),
    .wr_data (rx_data),
    .rd_en   (rd_en),
    .rd_data (o_rd_data),
    .empty   (o_empty),
    .full    (o_full),
    .wr_fire (wr_fire),
    .rd_fire (rd_fire)
  );

  // Sticky overrun: a dropped good byte sets, clear loses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overrun <= 1'b0;
    end else if (rx_valid && !wr_fire) begin
      o_overrun <= 1'b1;
    end else if (i_clr_err) begin
      o_overrun <= 1'b0;
    end
  end

  // Read strobe: one-cycle valid after an accepted pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_rd_valid <= 1'b0;
    else        o_rd_valid <= rd_fire;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed 8N1 frames, scoreboard
// queue of expected bytes checked by a read monitor.
module tb_uart_rx_fifo;

  localparam int BC = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rxp = 1'b1;
  logic       rd_en = 1'b0;
  logic       i_clr_err = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       o_empty;
  logic       o_full;
  logic       o_frame_err;
  logic       o_overrun;

  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(
    .baud_cycles (BC),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rxp       (i_rxp),
    .rd_en       (rd_en),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .i_clr_err   (i_clr_err)
  );

  always #5 clk = ~clk;

  // Monitor: pop expected byte on every read strobe
  always @(negedge clk) begin
    logic [7:0] e;
    if (o_rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %02h, none due",
                 o_rd_data);
      end else begin
        e = exp_q.pop_front();
        if (o_rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %02h, want %02h",
                   o_rd_data, e);
        end
      end
    end
    if (o_frame_err) fe_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop);
    i_rxp = 1'b0;
    tick(BC);
    for (int i = 0; i < 8; i++) begin
      i_rxp = b[i];
      tick(BC);
    end
    i_rxp = stop;
    tick(BC);
    i_rxp = 1'b1;
  endtask

  task automatic wait_not_empty(input string name);
    int n = 0;
    while (o_empty && n < 20) begin
      tick(1);
      n++;
    end
    check(name, o_empty, 1'b0);
  endtask

  task automatic read_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(2);
  endtask

  initial begin
    int fe0;
    tick(3);
    check("rst_empty", o_empty, 1'b1);
    check("rst_full", o_full, 1'b0);
    check("rst_valid", o_rd_valid, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_frame_err", o_frame_err, 1'b0);
    check("rst_data", o_rd_data, 8'h00);
    rst_n = 1'b1;
    tick(3);

    // 1: single frame, exact flag latency, read back
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check("t1_empty_e0", o_empty, 1'b1);
    tick(1);
    check("t1_empty_e1", o_empty, 1'b1);
    tick(1);
    check("t1_empty_e2", o_empty, 1'b0);
    read_one();
    check("t1_empty_after", o_empty, 1'b1);

    // 2: sixteen back-to-back frames fill the FIFO
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    tick(4);
    check("t2_full", o_full, 1'b1);
    check("t2_not_empty", o_empty, 1'b0);

    // 3: extra frame while full -> overrun, then clear
    send_frame(8'hFF, 1'b1);
    tick(4);
    check("t3_overrun", o_overrun, 1'b1);
    check("t3_still_full", o_full, 1'b1);
    i_clr_err = 1'b1;
    tick(1);
    i_clr_err = 1'b0;
    check("t3_overrun_clr", o_overrun, 1'b0);
    for (int i = 0; i < 16; i++) read_one();
    check("t2_empty", o_empty, 1'b1);
    check("t2_drained", exp_q.size(), 0);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(2);
    check("rd_when_empty", o_empty, 1'b1);

    // 4: stop bit low -> one frame error, nothing stored
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    i_rxp = 1'b0;
    tick(10);
    i_rxp = 1'b1;
    tick(10);
    check("t4_fe_pulses", fe_cnt - fe0, 1);
    check("t4_empty", o_empty, 1'b1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_not_empty("t4_good_arrives");
    read_one();

    // 5: two-cycle glitch on idle line is ignored
    fe0 = fe_cnt;
    i_rxp = 1'b0;
    tick(2);
    i_rxp = 1'b1;
    tick(20);
    check("t5_empty", o_empty, 1'b1);
    check("t5_no_fe", fe_cnt - fe0, 0);
    check("t5_no_overrun", o_overrun, 1'b0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_not_empty("t5_next_frame");
    read_one();

    // 6: reset during bit 4 of 0x81, with a byte queued
    send_frame(8'h77, 1'b1);
    wait_not_empty("t6_pre_byte");
    i_rxp = 1'b0;
    tick(BC);
    for (int i = 0; i < 4; i++) begin
      i_rxp = (i == 0);
      tick(BC);
    end
    i_rxp = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_empty", o_empty, 1'b1);
    check("t6_rst_full", o_full, 1'b0);
    check("t6_rst_data", o_rd_data, 8'h00);
    check("t6_rst_valid", o_rd_valid, 1'b0);
    check("t6_rst_fe", o_frame_err, 1'b0);
    check("t6_rst_overrun", o_overrun, 1'b0);
    i_rxp = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_not_empty("t6_frame_after");
    read_one();
    check("t6_empty", o_empty, 1'b1);

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
